// File: rtl/risc_pkg.sv
// Shared encodings, FSM state type and instruction layout for the parametrised RISC core.
package risc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned RIDX_W  = 3;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_GET_A,
    ST_GET_B,
    ST_ALU,
    ST_WR_RD,
    ST_WR_IMM
  } state_e;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [RIDX_W-1:0] rn;
    logic [RIDX_W-1:0] rd;
    logic [1:0]        sh;
    logic [RIDX_W-1:0] rm;
  } instr_t;

endpackage

// File: rtl/risc_regfile.sv
// Register file: one write port, two combinational read ports; indices at or
// above NREGS read as zero and silently drop writes.
module risc_regfile
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RIDX_W-1:0] raddr_a_i,
  input  logic [RIDX_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] regs_q [NREGS];

  logic wvalid_c, avalid_c, bvalid_c;

  assign wvalid_c = 32'(waddr_i)   < NREGS;
  assign avalid_c = 32'(raddr_a_i) < NREGS;
  assign bvalid_c = 32'(raddr_b_i) < NREGS;

  // Contents survive reset by design; only the core FSM is reset.
  always_ff @(posedge clk) begin
    if (we_i && wvalid_c) begin
      regs_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_a_o = avalid_c ? regs_q[raddr_a_i[AW-1:0]] : '0;
  assign rdata_b_o = bvalid_c ? regs_q[raddr_b_i[AW-1:0]] : '0;

endmodule

// File: rtl/risc_core_p.sv
// Parametrised multi-cycle RISC core: external instruction load, shifter on B,
// ALU with N/V/Z flags, done pulse and sticky err for undefined encodings.
module risc_core_p
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic               load,
  input  logic [INSTR_W-1:0] in,
  output logic [DATA_W-1:0]  out,
  output logic               N,
  output logic               V,
  output logic               Z,
  output logic               w,
  output logic               done,
  output logic               err
);

  localparam int unsigned MSB = DATA_W - 1;

  state_e            state_q, state_d;
  instr_t            ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic              n_q, n_d, v_q, v_d, z_q, z_d;
  logic              w_q, w_d, done_q, done_d, err_q, err_d;

  logic              rf_we_c;
  logic [RIDX_W-1:0] rf_waddr_c;
  logic [DATA_W-1:0] rf_wdata_c;
  logic [DATA_W-1:0] rdata_a_c, rdata_b_c;

  logic [7:0]        imm8_c;
  logic [DATA_W-1:0] imm_sext_c;
  logic [DATA_W-1:0] bsh_c, ain_c, res_c;
  logic              ovf_c;
  logic              is_alu_c, is_mov_c;

  risc_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk       (clk),
    .we_i      (rf_we_c),
    .waddr_i   (rf_waddr_c),
    .wdata_i   (rf_wdata_c),
    .raddr_a_i (ir_q.rn),
    .raddr_b_i (ir_q.rm),
    .rdata_a_o (rdata_a_c),
    .rdata_b_o (rdata_b_c)
  );

  assign is_alu_c   = (ir_q.opcode == OPC_ALU);
  assign is_mov_c   = (ir_q.opcode == OPC_MOV);
  assign imm8_c     = {ir_q.rd, ir_q.sh, ir_q.rm};
  assign imm_sext_c = {{(DATA_W-8){imm8_c[7]}}, imm8_c};

  // Single-bit shifter on the B operand.
  always_comb begin
    bsh_c = b_q;
    case (ir_q.sh)
      SH_LSL:  bsh_c = {b_q[MSB-1:0], 1'b0};
      SH_LSR:  bsh_c = {1'b0, b_q[MSB:1]};
      SH_ASR:  bsh_c = {b_q[MSB], b_q[MSB:1]};
      default: bsh_c = b_q;
    endcase
  end

  // MOV reg and MVN ignore the A operand.
  assign ain_c = (is_mov_c || (ir_q.op == ALU_MVN)) ? '0 : a_q;

  always_comb begin
    res_c = bsh_c;
    ovf_c = 1'b0;
    if (is_alu_c) begin
      case (ir_q.op)
        ALU_ADD: begin
          res_c = ain_c + bsh_c;
          ovf_c = (ain_c[MSB] == bsh_c[MSB]) && (res_c[MSB] != ain_c[MSB]);
        end
        ALU_CMP: begin
          res_c = ain_c - bsh_c;
          ovf_c = (ain_c[MSB] != bsh_c[MSB]) && (res_c[MSB] != ain_c[MSB]);
        end
        ALU_AND: res_c = ain_c & bsh_c;
        default: res_c = ~bsh_c;
      endcase
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    n_d        = n_q;
    v_d        = v_q;
    z_d        = z_q;
    err_d      = err_q;
    rf_we_c    = 1'b0;
    rf_waddr_c = ir_q.rd;
    rf_wdata_c = c_q;

    case (state_q)
      ST_WAIT: begin
        if (load) begin
          ir_d = instr_t'(in);
        end
        if (s) begin
          state_d = ST_DECODE;
          err_d   = 1'b0;
        end
      end
      ST_DECODE: begin
        if (is_mov_c && (ir_q.op == MOV_IMM)) begin
          state_d = ST_WR_IMM;
        end else if (is_mov_c && (ir_q.op == MOV_REG)) begin
          state_d = ST_GET_B;
        end else if (is_alu_c) begin
          state_d = (ir_q.op == ALU_MVN) ? ST_GET_B : ST_GET_A;
        end else begin
          state_d = ST_WAIT;
          err_d   = 1'b1;
        end
      end
      ST_GET_A: begin
        a_d     = rdata_a_c;
        state_d = ST_GET_B;
      end
      ST_GET_B: begin
        b_d     = rdata_b_c;
        state_d = ST_ALU;
      end
      ST_ALU: begin
        c_d = res_c;
        if (is_alu_c) begin
          n_d = res_c[MSB];
          z_d = (res_c == '0);
          v_d = ovf_c;
        end
        state_d = (is_alu_c && (ir_q.op == ALU_CMP)) ? ST_WAIT : ST_WR_RD;
      end
      ST_WR_RD: begin
        rf_we_c = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WR_IMM: begin
        rf_we_c    = 1'b1;
        rf_waddr_c = ir_q.rn;
        rf_wdata_c = imm_sext_c;
        state_d    = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase

    // A reset on this edge aborts any pending write-back.
    if (reset) begin
      rf_we_c = 1'b0;
    end

    w_d    = (state_d == ST_WAIT);
    done_d = (state_q != ST_WAIT) && (state_d == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      w_q     <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      w_q     <= w_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out  = c_q;
  assign N    = n_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign w    = w_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
